// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// state encodings, instruction width and default load address.
package instr_mem_loader_pkg;

  localparam int          INSTR_W           = 32;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_WORD,
    S_FLUSH,
    S_DONE
  } loader_state_t;

  // The stream is only consumed while the header or program words are expected.
  function automatic logic takes_bytes(loader_state_t s);
    return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_WORD);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input plus instruction-memory write port and core control
// between the program source and the loader.
interface instr_mem_loader_if;
  import instr_mem_loader_pkg::*;

  logic               Start;
  logic [7:0]         InByte;
  logic               InValid;
  logic               InReady;
  logic [INSTR_W-1:0] WriteData;
  logic [31:0]        WriteAddress;
  logic               WriteEnable;
  logic               CoreHold;
  logic               Done;
  logic               Overflow;

  modport master (
    output Start, InByte, InValid,
    input  InReady, WriteData, WriteAddress, WriteEnable, CoreHold, Done, Overflow
  );

  modport slave (
    input  Start, InByte, InValid,
    output InReady, WriteData, WriteAddress, WriteEnable, CoreHold, Done, Overflow
  );

endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Collects big-endian bytes into 32-bit words; flags the cycle in which the
// fourth byte is taken and presents the completed word combinationally.
module instr_mem_loader_word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               clear,
  input  logic               take,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic               word_done
);

  logic [23:0] sr_reg;
  logic [23:0] sr_next;
  logic [1:0]  byte_idx_reg;

  // Each lane moves one byte toward the MSB end as a new byte arrives.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign sr_next[7:0] = data;
      end else begin : g_rest
        assign sr_next[gi*8 +: 8] = sr_reg[(gi-1)*8 +: 8];
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      sr_reg       <= '0;
      byte_idx_reg <= '0;
    end else if (take) begin
      sr_reg       <= sr_next;
      byte_idx_reg <= byte_idx_reg + 2'd1;
    end
  end

  assign word      = {sr_reg, data};
  assign word_done = take && (byte_idx_reg == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: reads a word-count header and program words from a byte stream,
// writes them into instruction memory and keeps the core stalled until finished.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 16
) (
  input logic               Clk,
  input logic               Rst,
  instr_mem_loader_if.slave bus
);

  loader_state_t      state_reg;
  logic [7:0]         hdr_hi_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   word_idx_reg;
  logic [INSTR_W-1:0] write_data_reg;
  logic [31:0]        write_address_reg;
  logic               write_enable_reg;
  logic               core_hold_reg;
  logic               done_reg;
  logic               overflow_reg;

  logic               accept;
  logic               start_ok;
  logic               word_done;
  logic [INSTR_W-1:0] word;
  logic [CNT_W-1:0]   header_n;
  logic [31:0]        idx_ext;
  logic               in_range;
  logic               last_word;

  assign bus.InReady = takes_bytes(state_reg);
  assign accept      = bus.InValid && bus.InReady;
  assign start_ok    = bus.Start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign header_n    = CNT_W'({hdr_hi_reg, bus.InByte});
  assign idx_ext     = 32'(word_idx_reg);
  assign in_range    = idx_ext < 32'(DEPTH);
  assign last_word   = word_idx_reg == (count_reg - CNT_W'(1));

  instr_mem_loader_word_assembler u_asm (
    .Clk       (Clk),
    .Rst       (Rst),
    .clear     (start_ok),
    .take      (accept && (state_reg == S_WORD)),
    .data      (bus.InByte),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg         <= S_IDLE;
      hdr_hi_reg        <= '0;
      count_reg         <= '0;
      word_idx_reg      <= '0;
      write_data_reg    <= '0;
      write_address_reg <= BASE_ADDR;
      write_enable_reg  <= 1'b0;
      core_hold_reg     <= 1'b1;
      done_reg          <= 1'b0;
      overflow_reg      <= 1'b0;
    end else begin
      write_enable_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            state_reg         <= S_HDR_HI;
            done_reg          <= 1'b0;
            core_hold_reg     <= 1'b1;
            overflow_reg      <= 1'b0;
            word_idx_reg      <= '0;
            write_address_reg <= BASE_ADDR;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            hdr_hi_reg <= bus.InByte;
            state_reg  <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            count_reg <= header_n;
            state_reg <= (header_n == '0) ? S_FLUSH : S_WORD;
          end
        end
        S_WORD: begin
          if (word_done) begin
            word_idx_reg <= word_idx_reg + CNT_W'(1);
            // Words past the memory end are still consumed, just never written.
            if (in_range) begin
              write_enable_reg  <= 1'b1;
              write_data_reg    <= word;
              write_address_reg <= BASE_ADDR + {idx_ext[29:0], 2'b00};
            end else begin
              overflow_reg <= 1'b1;
            end
            if (last_word) begin
              state_reg <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // The final strobe is on the bus during this cycle; release the core after it.
          state_reg     <= S_DONE;
          done_reg      <= 1'b1;
          core_hold_reg <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.WriteData    = write_data_reg;
  assign bus.WriteAddress = write_address_reg;
  assign bus.WriteEnable  = write_enable_reg;
  assign bus.CoreHold     = core_hold_reg;
  assign bus.Done         = done_reg;
  assign bus.Overflow     = overflow_reg;

endmodule
